// File: rtl/seq_sm_mul.sv
// ---------------------------------------------------------------------------
// seq_sm_mul -- sequential sign-magnitude multiplier (shift-and-add).
//
// Operands are sign-magnitude: bit WIDTH-1 is the sign, bits WIDTH-2..0 the
// magnitude (M = WIDTH-1 bits). The product is sign-magnitude on RW = 2*M+1
// bits. One magnitude bit of the multiplier is consumed per RUN cycle, so an
// operation takes M RUN cycles plus one DONE cycle. A zero magnitude on
// either operand skips RUN and goes straight to DONE.
//
// Parameters
//   WIDTH        total operand width, 2..16
//   NORM_ZERO    1: zero products get a positive sign; 0: keep XOR sign
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   start         request, only looked at while IDLE
//   SAB           sign-magnitude multiplicand
//   SCD           sign-magnitude multiplier
//   result        registered sign-magnitude product
//   zeroFlag      registered: product magnitude is zero (sign ignored)
//   negativeFlag  registered: copy of result sign bit
//   busy          high whenever the FSM is not IDLE
//   done          one-cycle pulse while the FSM is in DONE
// ---------------------------------------------------------------------------
module seq_sm_mul #(
    parameter int WIDTH     = 3,
    parameter int NORM_ZERO = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   SAB,
    input  logic [WIDTH-1:0]   SCD,
    output logic [2*WIDTH-2:0] result,
    output logic               zeroFlag,
    output logic               negativeFlag,
    output logic               busy,
    output logic               done
);

    localparam int M  = WIDTH - 1;        // magnitude width
    localparam int RW = 2 * M + 1;        // result width
    localparam int CW = $clog2(M + 1);    // counter must hold the value M

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q;
    logic [2*M-1:0]  mcand_q;     // multiplicand magnitude, shifted left each step
    logic [M-1:0]    mplr_q;      // multiplier magnitude, shifted right each step
    logic [2*M-1:0]  acc_q;       // partial-product accumulator
    logic [CW-1:0]   cnt_q;       // remaining RUN steps
    logic            sign_q;      // captured product sign (XOR of operand signs)
    logic [RW-1:0]   result_q;
    logic            zero_q;
    logic            neg_q;
    logic            busy_q;
    logic            done_q;

    logic [2*M-1:0]  acc_d;
    logic            final_sign;
    logic            start_sign;
    logic            start_zero;
    logic            zero_sign;

    // Next accumulator value and the sign the result will carry when it is
    // written. In the last RUN step acc_d is already the full product.
    // NOTE: every signal driven from always_comb gets a value on every path
    // (here a default first); a path that leaves one unassigned infers a latch.
    always_comb begin
        acc_d = acc_q;
        if (mplr_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
        final_sign = sign_q;
        if ((NORM_ZERO != 0) && (acc_d == '0)) begin
            final_sign = 1'b0;
        end
    end

    assign start_sign = SAB[M] ^ SCD[M];
    assign start_zero = (SAB[M-1:0] == '0) || (SCD[M-1:0] == '0);
    // Zero shortcut: the magnitude is known to be zero, so only the sign
    // policy decides between +0 and -0.
    assign zero_sign  = (NORM_ZERO != 0) ? 1'b0 : start_sign;

    // Single FSM process; all outputs are registered alongside the state.
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sign_q  <= start_sign;
                        mcand_q <= {{M{1'b0}}, SAB[M-1:0]};
                        mplr_q  <= SCD[M-1:0];
                        acc_q   <= '0;
                        cnt_q   <= CW'(M);
                        busy_q  <= 1'b1;
                        if (start_zero) begin
                            result_q <= {zero_sign, {(RW-1){1'b0}}};
                            zero_q   <= 1'b1;
                            neg_q    <= zero_sign;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= RUN;
                        end
                    end
                end

                RUN: begin
                    acc_q   <= acc_d;
                    mcand_q <= mcand_q << 1;
                    mplr_q  <= mplr_q >> 1;
                    cnt_q   <= cnt_q - CW'(1);
                    // Last step: acc_d holds the complete product, publish it
                    // together with both flags as DONE is entered.
                    if (cnt_q == CW'(1)) begin
                        result_q <= {final_sign, acc_d};
                        zero_q   <= (acc_d == '0);
                        neg_q    <= final_sign;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end

                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign result       = result_q;
    assign zeroFlag     = zero_q;
    assign negativeFlag = neg_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
